// File: rtl/counter_sequencer.sv
// Load/count sequencer driving an external 4-bit counter from preset to terminal.
// Optional sticky wrap flag built only when SEQ_WRAP_FLAG_EN is defined.
module counter_sequencer (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] preset,
  input  logic [3:0] terminal,
  input  logic [2:0] step,
  input  logic [3:0] a_count,
  input  logic       c_out,
  output logic       load,
  output logic       count,
  output logic [3:0] din,
  output logic       busy,
  output logic       done,
  output logic       wrapped
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] preset_q, preset_d;
  logic [3:0] term_q, term_d;
  logic [2:0] step_q, step_d;
  logic [2:0] presc_q, presc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept;
  logic       tick;
  logic       at_term;

  always_comb begin
    accept   = (state_q == IDLE) && start && !abort;
    tick     = (presc_q == step_q);
    at_term  = (a_count == term_q);
    state_d  = state_q;
    preset_d = preset_q;
    term_d   = term_q;
    step_d   = step_q;
    presc_d  = presc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = LOAD;
          preset_d = preset;
          term_d   = terminal;
          step_d   = step;
          presc_d  = 3'd0;
        end
      end
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (at_term) begin
          state_d = DONE;
        end else begin
          presc_d = tick ? 3'd0 : presc_q + 3'd1;
        end
      end
      DONE: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // abort suppresses the command in the very cycle it is seen
  assign load  = (state_q == LOAD) && !abort;
  assign count = (state_q == RUN) && tick && !at_term && !abort;
  assign din   = preset_q;
  assign busy  = busy_q;
  assign done  = done_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      preset_q <= 4'd0;
      term_q   <= 4'd0;
      step_q   <= 3'd0;
      presc_q  <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      term_q   <= term_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SEQ_WRAP_FLAG_EN
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (accept) begin
      wrap_d = 1'b0;
    end else if (count && c_out) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrapped = wrap_q;
`else
  logic unused_c_out;
  assign unused_c_out = c_out;
  assign wrapped      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural downstream counter
// and a scoreboard of expected per-run results.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       clear, start, abort;
  logic [3:0] preset, terminal;
  logic [2:0] step;
  logic [3:0] a_count = 4'd0;
  logic       c_out;
  logic       load, count, busy, done, wrapped;
  logic [3:0] din;

  typedef struct {
    int         pulses;
    int         lat;
    int         gap;
    logic       wrap;
    logic [3:0] din;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  counter_sequencer dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .abort   (abort),
    .preset  (preset),
    .terminal(terminal),
    .step    (step),
    .a_count (a_count),
    .c_out   (c_out),
    .load    (load),
    .count   (count),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;

  // downstream counter: responds one cycle after load/count
  always @(posedge clk) begin
    if (load) a_count <= din;
    else if (count) a_count <= a_count + 4'd1;
  end
  assign c_out = (a_count == 4'hF);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [3:0] p, input logic [3:0] t,
                     input logic [2:0] s);
    exp_t e;
    preset   = p;
    terminal = t;
    step     = s;
    start    = 1'b1;
    e.pulses = int'((t - p) & 4'hF);
    e.gap    = int'(s) + 1;
    e.lat    = e.pulses * e.gap + 3;
    e.din    = p;
`ifdef SEQ_WRAP_FLAG_EN
    e.wrap   = (t < p);
`else
    e.wrap   = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic watch(input int bs_k, input logic [3:0] np);
    exp_t       e;
    int         pulses = 0;
    int         last   = -1;
    int         done_k = -1;
    int         xload  = 0;
    int         gap;
    bit         gap_ok = 1'b1;
    logic       w      = 1'b0;
    logic [3:0] d1     = 4'd0;
    gap = sb[0].gap;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (bs_k != 0 && k == bs_k) begin
        start  = 1'b1;
        preset = np;
      end
      if (bs_k != 0 && k == bs_k + 2) start = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        chk("load_first_cycle", load, 1);
        d1 = din;
      end else if (load) begin
        xload++;
      end
      if (count) begin
        if (last >= 0 && k - last != gap) gap_ok = 1'b0;
        last = k;
        pulses++;
      end
      if (done) begin
        done_k = k;
        w      = wrapped;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_seen", done_k >= 0, 1);
    chk("pulses", pulses, e.pulses);
    chk("done_cycle", done_k, e.lat);
    chk("pulse_gap", gap_ok, 1);
    chk("din_at_load", d1, e.din);
    chk("wrapped_at_done", w, e.wrap);
    chk("extra_load", xload, 0);
    @(posedge clk); #1;
    chk("idle_after_done", {busy, done}, 2'b00);
    chk("wrapped_in_idle", wrapped, e.wrap);
  endtask

  logic [3:0] a_hold;

  initial begin
    clear = 1'b1; start = 1'b0; abort = 1'b0;
    preset = 4'd0; terminal = 4'd0; step = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {load, count, busy, done, wrapped}, 5'b0);
    chk("rst_din", din, 4'd0);
    clear = 1'b0;
    @(posedge clk); #1;

    arm(4'd3, 4'd7, 3'd0);  watch(0, 4'd0);
    arm(4'd5, 4'd5, 3'd0);  watch(0, 4'd0);
    arm(4'd14, 4'd2, 3'd0); watch(0, 4'd0);
    arm(4'd0, 4'd3, 3'd2);  watch(0, 4'd0);
    arm(4'd0, 4'd5, 3'd1);  watch(3, 4'd9);

    // abort after two count pulses
    preset = 4'd0; terminal = 4'd9; step = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_count", count, 0);
    chk("abort_a_count", a_count, 4'd2);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {busy, done}, 2'b00);
    @(posedge clk); #1;
    chk("abort_no_done", {busy, done, load}, 3'b000);
    arm(4'd2, 4'd6, 3'd0);  watch(0, 4'd0);

    // abort beats start in IDLE
    preset = 4'd1; terminal = 4'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", {busy, load}, 2'b00);

    // clear mid-run after the wrap has happened
    @(posedge clk); #1;
    preset = 4'd14; terminal = 4'd2; step = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`ifdef SEQ_WRAP_FLAG_EN
    chk("wrap_before_clear", wrapped, 1);
`else
    chk("wrap_before_clear", wrapped, 0);
`endif
    #2;
    clear = 1'b1;
    #1;
    chk("clear_outs", {load, count, busy, done, wrapped}, 5'b0);
    chk("clear_din", din, 4'd0);
    a_hold = a_count;
    arm(4'd4, 4'd1, 3'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_a_count_held", a_count, a_hold);
    chk("clear_start_ignored", {busy, load}, 2'b00);
    clear = 1'b0;
    watch(0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 clear  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  request a count run; sampled in IDLE only.
REQ-004 abort  input  1  cancel the current run; sampled in every state.
REQ-005 preset  input  4  counter start value; captured when start is accepted.
REQ-006 terminal  input  4  stop value; captured when start is accepted.
REQ-007 step  input  3  count pulse spacing of step+1 cycles; captured when start is accepted.
REQ-008 a_count  input  4  current value fed back from the downstream 4-bit counter.
REQ-009 c_out  input  1  all-ones flag fed back from the downstream counter.
REQ-010 load  output  1  parallel-load command to the counter.
REQ-011 count  output  1  increment command to the counter.
REQ-012 din  output  4  load data; equals the captured preset.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when a run completes normally.
REQ-015 wrapped  output  1  sticky flag: the counter passed 15->0 during the run.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE, all registered.
REQ-017 IDLE->LOAD when start=1 and abort=0; capture preset, terminal and step, and clear wrapped and the prescaler.
REQ-018 LOAD SHALL last exactly 1 cycle with load=1 and count=0, then go to RUN.
REQ-019 The downstream counter SHALL take 1 cycle to respond: a_count reflects load/count in the cycle after assertion, so the first RUN cycle sees a_count=preset.
REQ-020 The 3-bit prescaler SHALL increment each RUN cycle; tick=1 when prescaler==captured step, and the prescaler returns to 0 on tick.
REQ-021 count SHALL equal (state==RUN) & tick & (a_count!=terminal_q), combinationally; load=0 in RUN.
REQ-022 RUN->DONE in the first cycle where a_count==terminal_q; no count is issued in that cycle.
REQ-023 DONE SHALL last 1 cycle with done=1, then return to IDLE; captured values SHALL be held until the next accepted start.
REQ-024 preset==terminal: RUN lasts exactly 1 cycle, zero count pulses; total start-to-done = LOAD, RUN, DONE.
REQ-025 terminal<preset: counting continues through 15->0 (wrap); the number of count pulses SHALL be (terminal-preset) mod 16.
REQ-026 abort=1 in LOAD or RUN: next state IDLE, no done pulse, and load/count are forced 0 in that same cycle.
REQ-027 abort and start both high in IDLE: abort wins and the run is not started; abort in DONE has no effect.
REQ-028 start while busy=1 SHALL be ignored and is not queued.
REQ-029 din SHALL be a register equal to the captured preset, stable from LOAD onward.

Reset
REQ-030 clear=1 SHALL immediately force IDLE and clear the prescaler, preset/terminal/step registers, din and wrapped to 0.
REQ-031 Under reset, load, count, busy, done and wrapped SHALL be 0, including reset asserted mid-RUN; no further pulses are issued.
REQ-032 The first accepted start SHALL be on the first rising edge after clear deasserts.

Configuration
REQ-033 Macro SEQ_WRAP_FLAG_EN.
- Defined: wrapped is set on a cycle with count=1 and c_out=1; it stays set until the next accepted start or reset, and is readable in DONE and IDLE.
- Undefined: no wrapped register is built and the wrapped port is tied to 0.

Verification
REQ-034 preset=3, terminal=7, step=0, start pulse -> load in cycle 1 with din=3; count high for 4 consecutive cycles; done 1 cycle after a_count=7; wrapped=0.
REQ-035 preset=5, terminal=5 -> load 1 cycle, 0 count pulses, done on the 3rd cycle after start.
REQ-036 preset=14, terminal=2, step=0, SEQ_WRAP_FLAG_EN defined -> 4 count pulses; wrapped=1 at done; without the macro, wrapped stays 0.
REQ-037 preset=0, terminal=3, step=2 -> count pulses exactly 3 cycles apart, 3 pulses total.
REQ-038 abort asserted after 2 count pulses -> count=0 in the same cycle, IDLE next, no done; a new start then runs normally.
REQ-039 clear asserted mid-RUN -> all outputs 0 asynchronously; start high while busy is ignored, checked with a_count unchanged.
